z_signature_checker: RTL and testbench
======================================

// Module: z_signature_checker
// PURPOSE
//  Downstream response stage for the sequential circuit under test. Samples its z output and a golden z_ref
//  (fault-free copy) over a fixed window, one sample per clk edge.
//  Compacts z into an LFSR signature and counts z/z_ref mismatches, giving a pass/fail verdict for fault-analysis runs.
// PARAMETERS
//  WINDOW   10     number of sampled cycles per run (>=1)
//  SIG_W    8      signature width (>=2)
//  POLY     8'h1D  signature feedback polynomial, SIG_W bits
//  SEED     8'hFF  signature value at reset/start
//  EXP_SIG  8'h00  expected fault-free signature, compared at end of run
//  CNT_W    8      mismatch counter width
// PORTS
//  clk            in   1      rising-edge clock, single clock domain
//  rst            in   1      synchronous reset, active-high
//  start          in   1      one-cycle pulse; begins a run
//  z              in   1      output of circuit under test
//  z_ref          in   1      golden output from fault-free circuit
//  busy           out  1      high while sampling (RUN)
//  done           out  1      high in DONE; results valid
//  signature      out  SIG_W  compacted z signature
//  mismatch_cnt   out  CNT_W  count of cycles with z != z_ref, saturating
//  fault_detected out  1      mismatch_cnt != 0 at end of run
//  sig_match      out  1      signature == EXP_SIG at end of run
//  first_fail     out  CNT_W  sample index of first mismatch (only with FIRST_FAIL_CAPTURE_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge, priority over all): state=IDLE; busy=0, done=0, signature=SEED, mismatch_cnt=0,
//    fault_detected=0, sig_match=0, first_fail=all-ones. Reset mid-RUN aborts the run; no partial result kept.
//  - FSM IDLE->RUN on start. RUN->DONE on the edge that takes sample WINDOW-1. DONE->RUN on start.
//    start while RUN is ignored. No other transitions.
//  - The start edge clears signature=SEED, mismatch_cnt=0, sample index=0, fault_detected=0, sig_match=0.
//    Samples are taken on the WINDOW edges that follow, so there are exactly WINDOW samples.
//  - Per sample (state RUN): fb = signature[SIG_W-1] ^ z.
//    signature <= {signature[SIG_W-2:0],1'b0} ^ ({SIG_W{fb}} & POLY).
//  - Per sample: if z!=z_ref, mismatch_cnt increments. It holds at all-ones and does not wrap.
//  - On the RUN->DONE edge: busy=0, done=1. fault_detected and sig_match register from the final
//    (post-last-sample) values.
//  - Outputs hold in DONE until the next start or rst. busy is high exactly WINDOW cycles per run.
//  - Latency start->done = WINDOW+1 edges.
//  - The sample index counter is wide enough for WINDOW-1 (clog2). It reaches WINDOW-1 and never wraps within a run.
// CONFIGURATION
//  FIRST_FAIL_CAPTURE_EN defined: the first_fail port exists.
//    It is set to all-ones at start, and latched to the sample index on the first mismatch of a run.
//    It is unchanged by later mismatches, and stays all-ones if there is no mismatch.
//  Macro undefined: the first_fail port and its register are absent; all other behaviour is identical.
// STRUCTURE
//  Package z_sig_pkg: FSM state enum {IDLE,RUN,DONE} and default POLY/SEED constants.
//  One sub-module: sig_lfsr. It is a combinational next-signature step (sig, z) -> sig_next,
//    parameterised by SIG_W/POLY. The FSM, counters and compare logic live in the top.
// TESTING (SIG_W=8, POLY=8'h1D, SEED=8'hFF, clk period 50)
//  1 rst high 2 edges -> busy=0, done=0, signature=8'hFF, mismatch_cnt=0.
//  2 WINDOW=5, z=z_ref=0, start pulse -> busy high 5 cycles, then done=1, signature=8'h96, mismatch_cnt=0,
//    fault_detected=0. With EXP_SIG=8'h96: sig_match=1.
//  3 WINDOW=10, z_ref=0, z=1 on samples 3 and 7 only -> mismatch_cnt=2, fault_detected=1;
//    first_fail=3 with macro, port absent without.
//  4 CNT_W=2, WINDOW=10, z!=z_ref every sample -> mismatch_cnt=3 (saturated, no wrap).
//  5 start pulsed again at sample 4 of a run -> ignored; done still asserts WINDOW+1 edges after the first start.
//  6 rst at sample 3 of a run, then start -> state IDLE after rst.
//    The new run's results match scenario 2 (signature=8'h96), with no carry-over.

Source files
------------

// File: rtl/z_sig_pkg.sv
// Shared types and default constants for the z signature checker.
//   state_e  : checker FSM states
//   DEF_POLY : default signature feedback polynomial (8-bit)
//   DEF_SEED : default signature start value (8-bit)
package z_sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'hFF;

endpackage

// File: rtl/sig_lfsr.sv
// Combinational single-step signature compactor.
// Ports:
//   sig_i      : current signature
//   z_i        : serial input bit being compacted
//   sig_next_o : signature after absorbing z_i
module sig_lfsr #(
    parameter int unsigned             SIG_W = 8,
    parameter logic [SIG_W-1:0]        POLY  = SIG_W'(8'h1D)
) (
    input  logic [SIG_W-1:0] sig_i,
    input  logic             z_i,
    output logic [SIG_W-1:0] sig_next_o
);

    logic fb;

    // Feedback mixes the outgoing MSB with the new input bit.
    assign fb         = sig_i[SIG_W-1] ^ z_i;
    assign sig_next_o = {sig_i[SIG_W-2:0], 1'b0} ^ ({SIG_W{fb}} & POLY);

endmodule

// File: rtl/z_signature_checker.sv
// Response checker: samples z and z_ref for WINDOW cycles after a start pulse,
// compacts z into a signature and counts z/z_ref mismatches (saturating).
// Optional feature macro: FIRST_FAIL_CAPTURE_EN adds the first_fail port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse that begins a run (ignored while busy)
//   z, z_ref        : response under test and golden response
//   busy            : high while sampling
//   done            : high when results are valid, held until next start
//   signature       : compacted z signature
//   mismatch_cnt    : saturating count of z != z_ref samples
//   fault_detected  : mismatch_cnt != 0 at end of run
//   sig_match       : signature == EXP_SIG at end of run
//   first_fail      : sample index of first mismatch, all-ones if none
module z_signature_checker
    import z_sig_pkg::*;
#(
    parameter int unsigned      WINDOW  = 10,
    parameter int unsigned      SIG_W   = 8,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
    parameter logic [SIG_W-1:0] EXP_SIG = SIG_W'(8'h00),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z,
    input  logic             z_ref,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fault_detected,
`ifdef FIRST_FAIL_CAPTURE_EN
    output logic             sig_match,
    output logic [CNT_W-1:0] first_fail
`else
    output logic             sig_match
`endif
);

    localparam int unsigned IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d, sig_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic               match_q, match_d;
    logic               last_sample;
    logic               mismatch;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [CNT_W-1:0]   ff_q, ff_d;
`endif

    sig_lfsr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_sig_lfsr (
        .sig_i      (sig_q),
        .z_i        (z),
        .sig_next_o (sig_next)
    );

    assign last_sample = (idx_q == IDX_W'(WINDOW - 1));
    assign mismatch    = z ^ z_ref;

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            match_q <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            ff_q    <= '1;
`endif
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            match_q <= match_d;
`ifdef FIRST_FAIL_CAPTURE_EN
            ff_q    <= ff_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_sample) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fault_d = fault_q;
        match_d = match_q;
`ifdef FIRST_FAIL_CAPTURE_EN
        ff_d    = ff_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fault_d = 1'b0;
                    match_d = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
                    ff_d    = '1;
`endif
                end
            end
            RUN: begin
                sig_d = sig_next;
                if (mismatch && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
`ifdef FIRST_FAIL_CAPTURE_EN
                // A zero count means no mismatch yet this run (count never returns to 0).
                if (mismatch && (cnt_q == '0)) ff_d = CNT_W'(idx_q);
`endif
                if (last_sample) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fault_d = (cnt_d != '0);
                    match_d = (sig_d == EXP_SIG);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign signature      = sig_q;
    assign mismatch_cnt   = cnt_q;
    assign fault_detected = fault_q;
    assign sig_match      = match_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    assign first_fail     = ff_q;
`endif

endmodule

// File: tb/tb_z_signature_checker.sv
// Directed bench for z_signature_checker. Three instances share stimulus:
//   u5  : WINDOW=5,  EXP_SIG=8'h96
//   u10 : WINDOW=10, EXP_SIG=8'h37
//   uc2 : WINDOW=10, CNT_W=2 (saturation)
// Optional feature macro: FIRST_FAIL_CAPTURE_EN (first_fail checks).
module tb_z_signature_checker;

    logic clk = 1'b0;
    logic rst, start, z, z_ref;

    logic       busy5, done5, fd5, sm5;
    logic [7:0] sig5, mm5, ff5;
    logic       busy10, done10, fd10, sm10;
    logic [7:0] sig10, mm10, ff10;
    logic       busyc, donec, fdc, smc;
    logic [7:0] sigc;
    logic [1:0] mmc, ffc;

    int n_chk = 0;
    int n_err = 0;

    always #25 clk = ~clk;

    z_signature_checker #(.WINDOW(5), .EXP_SIG(8'h96)) u5 (
        .clk(clk), .rst(rst), .start(start), .z(z), .z_ref(z_ref),
        .busy(busy5), .done(done5), .signature(sig5), .mismatch_cnt(mm5),
        .fault_detected(fd5),
`ifdef FIRST_FAIL_CAPTURE_EN
        .first_fail(ff5),
`endif
        .sig_match(sm5));

    z_signature_checker #(.WINDOW(10), .EXP_SIG(8'h37)) u10 (
        .clk(clk), .rst(rst), .start(start), .z(z), .z_ref(z_ref),
        .busy(busy10), .done(done10), .signature(sig10), .mismatch_cnt(mm10),
        .fault_detected(fd10),
`ifdef FIRST_FAIL_CAPTURE_EN
        .first_fail(ff10),
`endif
        .sig_match(sm10));

    z_signature_checker #(.WINDOW(10), .CNT_W(2)) uc2 (
        .clk(clk), .rst(rst), .start(start), .z(z), .z_ref(z_ref),
        .busy(busyc), .done(donec), .signature(sigc), .mismatch_cnt(mmc),
        .fault_detected(fdc),
`ifdef FIRST_FAIL_CAPTURE_EN
        .first_fail(ffc),
`endif
        .sig_match(smc));

`ifndef FIRST_FAIL_CAPTURE_EN
    assign ff5  = 8'hFF;
    assign ff10 = 8'hFF;
    assign ffc  = 2'h3;
`endif

    typedef struct {
        string      name;
        logic [9:0] zp;     // z per sample, bit i = sample i
        logic [9:0] zrp;    // z_ref per sample
        logic [7:0] sig5;
        logic [7:0] mm5;
        logic [7:0] ff5;
        logic [7:0] sig10;
        logic [7:0] mm10;
        logic [7:0] ff10;
        logic [1:0] mmc;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One run: start pulse, then 10 samples; optional extra start at sample restart_at.
    task automatic run_vec(input logic [9:0] zp, input logic [9:0] zrp, input int restart_at,
                           input string tag);
        int busy_seen;
        int done_early;
        busy_seen  = 0;
        done_early = 0;
        @(posedge clk); #1;
        start = 1'b1; z = 1'b0; z_ref = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            z     = zp[i];
            z_ref = zrp[i];
            start = (i == restart_at);
            if (busy10) busy_seen++;
            if (done10) done_early++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, busy_seen, 10);
        chk({tag, "_done_early"}, done_early, 0);
        chk({tag, "_busy_end"}, busy10, 0);
        chk({tag, "_done10"}, done10, 1);
        chk({tag, "_done5"}, done5, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; z = 1'b0; z_ref = 1'b0;

        vt[0] = '{"zero",      10'h000, 10'h000, 8'h96, 8'd0, 8'hFF, 8'h37, 8'd0,  8'hFF, 2'd0};
        vt[1] = '{"z_s3_s7",   10'h088, 10'h000, 8'hAC, 8'd1, 8'd3,  8'h50, 8'd2,  8'd3,  2'd2};
        vt[2] = '{"all_mm",    10'h000, 10'h3FF, 8'h96, 8'd5, 8'd0,  8'h37, 8'd10, 8'd0,  2'd3};
        vt[3] = '{"ones_eq",   10'h3FF, 10'h3FF, 8'hE0, 8'd0, 8'hFF, 8'h27, 8'd0,  8'hFF, 2'd0};
        vt[4] = '{"mm_last",   10'h000, 10'h200, 8'h96, 8'd0, 8'hFF, 8'h37, 8'd1,  8'd9,  2'd1};
        vt[5] = '{"mm_first",  10'h000, 10'h001, 8'h96, 8'd1, 8'd0,  8'h37, 8'd1,  8'd0,  2'd1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy10, 0);
        chk("rst_done", done10, 0);
        chk("rst_sig", sig10, 8'hFF);
        chk("rst_mm", mm10, 0);
        chk("rst_fault", fd10, 0);
        chk("rst_match", sm5, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("rst_ff", ff10, 8'hFF);
`endif
        rst = 1'b0;

        // Table-driven runs.
        for (int k = 0; k < 6; k++) begin
            run_vec(vt[k].zp, vt[k].zrp, -1, vt[k].name);
            chk({vt[k].name, "_sig5"},   sig5,  vt[k].sig5);
            chk({vt[k].name, "_mm5"},    mm5,   vt[k].mm5);
            chk({vt[k].name, "_fd5"},    fd5,   vt[k].mm5 != 0);
            chk({vt[k].name, "_sm5"},    sm5,   vt[k].sig5 == 8'h96);
            chk({vt[k].name, "_sig10"},  sig10, vt[k].sig10);
            chk({vt[k].name, "_mm10"},   mm10,  vt[k].mm10);
            chk({vt[k].name, "_fd10"},   fd10,  vt[k].mm10 != 0);
            chk({vt[k].name, "_sm10"},   sm10,  vt[k].sig10 == 8'h37);
            chk({vt[k].name, "_mmc2"},   mmc,   vt[k].mmc);
            chk({vt[k].name, "_sigc2"},  sigc,  vt[k].sig10);
`ifdef FIRST_FAIL_CAPTURE_EN
            chk({vt[k].name, "_ff5"},    ff5,   vt[k].ff5);
            chk({vt[k].name, "_ff10"},   ff10,  vt[k].ff10);
`endif
        end

        // Results hold in DONE while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            z = 1'($urandom_range(0, 1)); z_ref = ~z;
            @(posedge clk); #1;
        end
        chk("hold_done", done10, 1);
        chk("hold_sig", sig10, 8'h37);
        chk("hold_mm", mm10, 1);

        // Start during RUN is ignored; done timing unchanged.
        run_vec(10'h000, 10'h000, 4, "restart");
        chk("restart_sig10", sig10, 8'h37);
        chk("restart_sig5", sig5, 8'h96);

        // Reset mid-run aborts; next run has no carry-over.
        @(posedge clk); #1;
        start = 1'b1; z = 1'b1; z_ref = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; z = 1'b0; z_ref = 1'b0;
        chk("abort_busy", busy10, 0);
        chk("abort_done", done10, 0);
        chk("abort_sig", sig10, 8'hFF);
        chk("abort_mm", mm10, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_idle_busy", busy10, 0);
        chk("abort_idle_done", done10, 0);
        run_vec(10'h000, 10'h000, -1, "post_abort");
        chk("post_abort_sig5", sig5, 8'h96);
        chk("post_abort_sm5", sm5, 1);
        chk("post_abort_mm10", mm10, 0);
        chk("post_abort_fd10", fd10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
